// File: rtl/rbfu_wb_scheduler_pkg.sv
// rtl/rbfu_wb_scheduler_pkg.sv - shared types, sizes and bus field helpers for the RBFU write-back scheduler
package rbfu_wb_scheduler_pkg;

  localparam int P     = 2;
  localparam int LANES = 2 * P;
  localparam int MAP   = 2;
  localparam int CNT_W = 16;

  typedef logic [MAP-1:0]       lane_idx_t;
  typedef logic [MAP-1:0]       bank_idx_t;
  typedef logic [LANES-1:0]     mask_t;
  typedef logic [LANES*MAP-1:0] bus_t;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_DRAIN = 1'b1
  } state_t;

  // Field idx of a packed *_bus word (field 0 in the low bits).
  function automatic lane_idx_t get_field(input bus_t bus, input int idx);
    return bus[idx*MAP +: MAP];
  endfunction

  // Returns bus with field idx replaced by val.
  function automatic bus_t put_field(input bus_t bus, input int idx, input lane_idx_t val);
    bus_t r_word;
    r_word = bus;
    r_word[idx*MAP +: MAP] = val;
    return r_word;
  endfunction

endpackage

// File: rtl/rbfu_wb_grant.sv
// rtl/rbfu_wb_grant.sv - combinational per-bank lowest-lane grant function
module rbfu_wb_grant
  import rbfu_wb_scheduler_pkg::*;
(
  input  mask_t i_mask,
  input  bus_t  i_dest_bus,
  output bus_t  o_sel_bus,
  output mask_t o_we,
  output mask_t o_granted,
  output mask_t o_live
);

  // For every bank pick the lowest requesting lane; scanning downward lets the lowest match win.
  always_comb begin
    o_sel_bus = '0;
    o_we      = '0;
    o_granted = '0;
    for (int k = 0; k < LANES; k++) begin
      for (int j = LANES - 1; j >= 0; j--) begin
        if (i_mask[j] && (int'(get_field(i_dest_bus, j)) == k)) begin
          o_sel_bus = put_field(o_sel_bus, k, lane_idx_t'(j));
          o_we[k]   = 1'b1;
        end
      end
      if (o_we[k]) begin
        o_granted[get_field(o_sel_bus, k)] = 1'b1;
      end
    end
  end

  // Live lanes: masked in and aimed at an existing bank; out-of-range destinations are dropped here.
  always_comb begin
    o_live = '0;
    for (int j = 0; j < LANES; j++) begin
      o_live[j] = i_mask[j] && (int'(get_field(i_dest_bus, j)) < LANES);
    end
  end

endmodule

// File: rtl/rbfu_wb_scheduler.sv
// rtl/rbfu_wb_scheduler.sv - write-back scheduler producing sel_BI_bus and serialising bank conflicts
module rbfu_wb_scheduler
  import rbfu_wb_scheduler_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 req_valid,
  output logic                 req_ready,
  input  logic [LANES-1:0]     req_lane_mask,
  input  logic [LANES*MAP-1:0] req_dest_bus,
  output logic [LANES*MAP-1:0] sel_BI_bus,
  output logic [LANES-1:0]     bank_we,
  output logic                 out_valid,
  output logic                 pipe_hold,
  output logic [CNT_W-1:0]     conflict_cnt
);

  state_t           r_state;
  state_t           w_state_nxt;
  mask_t            r_resid;
  mask_t            w_resid_nxt;
  bus_t             r_dest;
  bus_t             r_sel;
  mask_t            r_we;
  logic             r_out_valid;
  logic [CNT_W-1:0] r_cnt;

  logic  w_accept;
  logic  w_issue;
  mask_t w_g_mask;
  bus_t  w_g_dest;
  bus_t  w_g_sel;
  mask_t w_g_we;
  mask_t w_g_granted;
  mask_t w_g_live;

  assign w_accept = req_valid && req_ready;
  // A grant is computed on every accept and on every drain cycle.
  assign w_issue  = w_accept || (r_state == ST_DRAIN);
  // While draining, the stored residual lanes and destinations feed the grant; otherwise the new request does.
  assign w_g_mask = (r_state == ST_DRAIN) ? r_resid : req_lane_mask;
  assign w_g_dest = (r_state == ST_DRAIN) ? r_dest  : req_dest_bus;

  rbfu_wb_grant u_grant (
    .i_mask     (w_g_mask),
    .i_dest_bus (w_g_dest),
    .o_sel_bus  (w_g_sel),
    .o_we       (w_g_we),
    .o_granted  (w_g_granted),
    .o_live     (w_g_live)
  );

  // State register together with the residual lane mask it mirrors.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_IDLE;
      r_resid <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_resid <= w_resid_nxt;
    end
  end

  // Next state: residual is whatever live lanes were not granted; DRAIN while any remain.
  always_comb begin
    w_state_nxt = r_state;
    w_resid_nxt = r_resid;
    if (w_issue) begin
      w_resid_nxt = w_g_live & ~w_g_granted;
      w_state_nxt = (|w_resid_nxt) ? ST_DRAIN : ST_IDLE;
    end
  end

  // Registered grant outputs, stored destinations and saturating drain-cycle counter.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_dest      <= '0;
      r_sel       <= '0;
      r_we        <= '0;
      r_out_valid <= 1'b0;
      r_cnt       <= '0;
    end else begin
      if (w_accept) begin
        r_dest <= req_dest_bus;
      end
      if (w_issue) begin
        r_sel       <= w_g_sel;
        r_we        <= w_g_we;
        r_out_valid <= |w_g_we;
      end else begin
        r_we        <= '0;
        r_out_valid <= 1'b0;
      end
      if ((r_state == ST_DRAIN) && (r_cnt != '1)) begin
        r_cnt <= r_cnt + 1'b1;
      end
    end
  end

  // Outputs: handshake and hold derive from state; the rest come straight from registers.
  always_comb begin
    req_ready    = !rst && (r_state == ST_IDLE);
    pipe_hold    = (r_state == ST_DRAIN);
    sel_BI_bus   = r_sel;
    bank_we      = r_we;
    out_valid    = r_out_valid;
    conflict_cnt = r_cnt;
  end

endmodule

// File: tb/tb_rbfu_wb_scheduler.sv
// tb/tb_rbfu_wb_scheduler.sv - self-checking bench for rbfu_wb_scheduler
module tb_rbfu_wb_scheduler;

  logic        clk;
  logic        rst;
  logic        req_valid;
  logic        req_ready;
  logic [3:0]  req_lane_mask;
  logic [7:0]  req_dest_bus;
  logic [7:0]  sel_BI_bus;
  logic [3:0]  bank_we;
  logic        out_valid;
  logic        pipe_hold;
  logic [15:0] conflict_cnt;

  int n_checks;
  int n_errors;

  rbfu_wb_scheduler dut (
    .clk           (clk),
    .rst           (rst),
    .req_valid     (req_valid),
    .req_ready     (req_ready),
    .req_lane_mask (req_lane_mask),
    .req_dest_bus  (req_dest_bus),
    .sel_BI_bus    (sel_BI_bus),
    .bank_we       (bank_we),
    .out_valid     (out_valid),
    .pipe_hold     (pipe_hold),
    .conflict_cnt  (conflict_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic        r;
    logic        v;
    logic [3:0]  mask;
    logic [7:0]  dest;
    logic        rdy;
    logic [7:0]  sel;
    logic [3:0]  we;
    logic        vld;
    logic        hold;
    logic [15:0] cnt;
  } vec_t;

  vec_t tbl [14];

  // Reference model: one FIFO of pending lanes per bank, each popped once per output cycle.
  int          bq [4][$];
  logic [7:0]  m_sel;
  logic [3:0]  m_we;
  logic [15:0] m_cnt;

  function automatic bit m_busy();
    bit b;
    b = 1'b0;
    for (int k = 0; k < 4; k++) if (bq[k].size() > 0) b = 1'b1;
    return b;
  endfunction

  task automatic model_edge(input bit r, input bit v, input logic [3:0] mask, input logic [7:0] dest);
    bit busy;
    int d;
    if (r) begin
      for (int k = 0; k < 4; k++) bq[k].delete();
      m_sel = 8'h00;
      m_we  = 4'h0;
      m_cnt = 16'd0;
    end else begin
      busy = m_busy();
      if (!busy && v) begin
        for (int j = 0; j < 4; j++) begin
          d = int'(dest[j*2 +: 2]);
          if (mask[j] && d < 4) bq[d].push_back(j);
        end
      end
      if (busy || v) begin
        m_sel = 8'h00;
        m_we  = 4'h0;
        for (int k = 0; k < 4; k++) begin
          if (bq[k].size() > 0) begin
            m_sel[k*2 +: 2] = 2'(bq[k].pop_front());
            m_we[k] = 1'b1;
          end
        end
      end else begin
        m_we = 4'h0;
      end
      if (busy && m_cnt != 16'hFFFF) m_cnt = m_cnt + 16'd1;
    end
  endtask

  task automatic chk(input string name, input int cyc, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s cycle %0d: got %0h expected %0h", name, cyc, act, exp);
    end
  endtask

  task automatic drive(input bit r, input bit v, input logic [3:0] mask, input logic [7:0] dest);
    rst           = r;
    req_valid     = v;
    req_lane_mask = mask;
    req_dest_bus  = dest;
    #1;
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  // Drives one cycle and compares everything against the reference model.
  task automatic model_cycle(input int cyc, input bit r, input bit v, input logic [3:0] mask, input logic [7:0] dest);
    drive(r, v, mask, dest);
    chk("m_ready", cyc, 32'(req_ready), 32'(!r && !m_busy()));
    tick();
    model_edge(r, v, mask, dest);
    chk("m_sel",   cyc, 32'(sel_BI_bus),   32'(m_sel));
    chk("m_we",    cyc, 32'(bank_we),      32'(m_we));
    chk("m_valid", cyc, 32'(out_valid),    32'(|m_we));
    chk("m_hold",  cyc, 32'(pipe_hold),    32'(m_busy()));
    chk("m_cnt",   cyc, 32'(conflict_cnt), 32'(m_cnt));
  endtask

  initial begin
    logic [7:0] perm;
    n_checks = 0;
    n_errors = 0;

    //           r     v     mask  dest   rdy   sel    we    vld   hold  cnt
    tbl[0]  = '{1'b1, 1'b0, 4'h0, 8'h00, 1'b0, 8'h00, 4'h0, 1'b0, 1'b0, 16'd0};
    tbl[1]  = '{1'b0, 1'b1, 4'hF, 8'h1B, 1'b1, 8'h1B, 4'hF, 1'b1, 1'b0, 16'd0};
    tbl[2]  = '{1'b0, 1'b1, 4'hF, 8'hAA, 1'b1, 8'h00, 4'h4, 1'b1, 1'b1, 16'd0};
    tbl[3]  = '{1'b0, 1'b1, 4'hF, 8'h1B, 1'b0, 8'h10, 4'h4, 1'b1, 1'b1, 16'd1};
    tbl[4]  = '{1'b0, 1'b0, 4'h0, 8'h00, 1'b0, 8'h20, 4'h4, 1'b1, 1'b1, 16'd2};
    tbl[5]  = '{1'b0, 1'b0, 4'h0, 8'h00, 1'b0, 8'h30, 4'h4, 1'b1, 1'b0, 16'd3};
    tbl[6]  = '{1'b0, 1'b0, 4'h0, 8'h00, 1'b1, 8'h30, 4'h0, 1'b0, 1'b0, 16'd3};
    tbl[7]  = '{1'b0, 1'b1, 4'h5, 8'h55, 1'b1, 8'h00, 4'h2, 1'b1, 1'b1, 16'd3};
    tbl[8]  = '{1'b0, 1'b0, 4'h0, 8'h00, 1'b0, 8'h08, 4'h2, 1'b1, 1'b0, 16'd4};
    tbl[9]  = '{1'b0, 1'b1, 4'h0, 8'h1B, 1'b1, 8'h00, 4'h0, 1'b0, 1'b0, 16'd4};
    tbl[10] = '{1'b0, 1'b1, 4'hF, 8'hAA, 1'b1, 8'h00, 4'h4, 1'b1, 1'b1, 16'd4};
    tbl[11] = '{1'b0, 1'b0, 4'h0, 8'h00, 1'b0, 8'h10, 4'h4, 1'b1, 1'b1, 16'd5};
    tbl[12] = '{1'b1, 1'b0, 4'h0, 8'h00, 1'b0, 8'h00, 4'h0, 1'b0, 1'b0, 16'd0};
    tbl[13] = '{1'b0, 1'b0, 4'h0, 8'h00, 1'b1, 8'h00, 4'h0, 1'b0, 1'b0, 16'd0};

    rst           = 1'b1;
    req_valid     = 1'b0;
    req_lane_mask = 4'h0;
    req_dest_bus  = 8'h00;
    @(negedge clk);

    // Directed table: permutation, all-to-one drain, masked lanes, empty mask, reset mid-drain.
    for (int i = 0; i < 14; i++) begin
      drive(tbl[i].r, tbl[i].v, tbl[i].mask, tbl[i].dest);
      chk("t_ready", i, 32'(req_ready), 32'(tbl[i].rdy));
      tick();
      chk("t_sel",   i, 32'(sel_BI_bus),   32'(tbl[i].sel));
      chk("t_we",    i, 32'(bank_we),      32'(tbl[i].we));
      chk("t_valid", i, 32'(out_valid),    32'(tbl[i].vld));
      chk("t_hold",  i, 32'(pipe_hold),    32'(tbl[i].hold));
      chk("t_cnt",   i, 32'(conflict_cnt), 32'(tbl[i].cnt));
    end

    // Resynchronise the model with a reset, then back-to-back conflict-free permutations.
    model_cycle(100, 1'b1, 1'b0, 4'h0, 8'h00);
    for (int i = 0; i < 8; i++) begin
      perm = 8'h00;
      for (int j = 0; j < 4; j++) perm[j*2 +: 2] = 2'((j + i) % 4);
      model_cycle(200 + i, 1'b0, 1'b1, 4'hF, perm);
      chk("b2b_hold", 200 + i, 32'(pipe_hold), 32'd0);
    end

    // Randomised traffic with occasional resets.
    for (int i = 0; i < 600; i++) begin
      model_cycle(1000 + i,
                  $urandom_range(0, 49) == 0,
                  $urandom_range(0, 3) != 0,
                  4'($urandom),
                  8'($urandom));
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
